easyobv_test_seq: RTL and testbench
===================================

# easyobv_test_seq

Single-run test sequencer for the EasyOBV loopback observation path. It owns the traffic-generator enable and the AXI-Stream monitor's clear input, and runs one timed test per start request: clear, settle, run, drain, done. At the end it latches a consistent snapshot of the monitor counters and a status code for software or the top-level register block. It sits between the control registers and the `easyobv_axis_mon` / traffic-generator pair.

## Interface
- `CNT_WIDTH`, 32: width of the settle and run cycle counts.
- `CLEAR_CYCLES`, 4: cycles `mon_clear` is held high (≥1).
- `DRAIN_TIMEOUT`, 4096: maximum drain cycles before a timeout is declared (≥1).
- `clk` in 1: the block's single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a test; sampled only in IDLE.
- `abort` in 1: terminate the current test.
- `settle_cycles` in CNT_WIDTH: idle cycles between clear and run; 0 skips SETTLE.
- `run_cycles` in CNT_WIDTH: cycles `gen_en` is high; 0 is treated as 1.
- `mon_tx_pkt_cnt` in 64: live monitor TX packet count.
- `mon_rx_pkt_cnt` in 64: live monitor RX packet count.
- `mon_mismatch` in 1: live monitor mismatch flag.
- `mon_clear` out 1: clear to the monitor.
- `gen_en` out 1: traffic-generator enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `status` out 2: 0 OK, 1 MISMATCH, 2 DRAIN_TIMEOUT, 3 ABORTED; held until the next DONE.
- `snap_tx_pkt_cnt` out 64: snapshot of the TX count, latched on entry to DONE.
- `snap_rx_pkt_cnt` out 64: snapshot of the RX count, latched on entry to DONE.
- `snap_cycles` out CNT_WIDTH: RUN cycles actually executed.

## Operation
- States: IDLE, CLEAR, SETTLE, RUN, DRAIN, DONE.
- **IDLE:** when `start`=1, latch `settle_cycles` and `run_cycles`, clear the sticky mismatch, and go to CLEAR.
- **CLEAR:** `mon_clear`=1 for exactly CLEAR_CYCLES cycles. Then go to SETTLE, or to RUN if the latched settle count is 0.
- **SETTLE:** stay for exactly the latched settle count of cycles, then go to RUN.
- **RUN:** `gen_en`=1 for exactly max(run_cycles,1) cycles. `snap_cycles` counts these cycles. Then go to DRAIN.
- **DRAIN:** `gen_en`=0.
  - Exit to DONE with status OK when `mon_rx_pkt_cnt == mon_tx_pkt_cnt`, evaluated from the first DRAIN cycle.
  - If still unequal after DRAIN_TIMEOUT cycles, go to DONE with DRAIN_TIMEOUT.
- **DONE:** lasts one cycle, then IDLE. The snapshot registers and `status` are loaded when entering DONE.
- Sticky mismatch: set whenever `mon_mismatch`=1 during RUN or DRAIN. An OK drain exit with sticky mismatch set reports MISMATCH.
- Status priority: ABORTED > DRAIN_TIMEOUT > MISMATCH > OK.
- Abort: `abort`=1 in any state other than IDLE/DONE moves the block to DONE next cycle with ABORTED. `gen_en` and `mon_clear` drop at that edge. Abort in IDLE or DONE is ignored.
- `start` while busy is ignored; no queuing.
- `start` and `abort` together in IDLE: start wins.
- All counters saturate; none wrap. Counter comparisons use the full 64-bit width.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - `mon_clear`, `gen_en`, `busy`, `done` = 0.
  - `status` = 0.
  - snapshots = 0, `snap_cycles` = 0.
- All outputs are registered, with no combinational input-to-output path.
- `start` at edge N gives `busy`=1 and `mon_clear`=1 from cycle N+1.
- With settle=S>0 and run=R: `gen_en` is high in cycles N+1+CLEAR_CYCLES+S through N+CLEAR_CYCLES+S+R.
- Earliest `done` is 1 cycle after RUN ends, when counts already match.
- Reset asserted mid-test drops `gen_en` and `mon_clear` immediately. No DONE and no snapshot update occur.

## Test plan
- **Nominal run:** CLEAR_CYCLES=4, settle=3, run=10, counts equal at drain. Required response:
  - `mon_clear` high 4 cycles; `gen_en` high exactly 10 cycles.
  - `done` 19 cycles after start.
  - status=0, `snap_cycles`=10, snapshots equal to the live counts.
- **Zero counts:** settle=0, run=0. Required response: no SETTLE; `gen_en` high exactly 1 cycle; status=0.
- **Mismatch:** `mon_mismatch` pulsed 1 cycle mid-RUN, counts later equal. Required response: status=1.
- **Drain timeout:** DRAIN_TIMEOUT=8, rx=tx−1 held. Required response: `done` after 8 DRAIN cycles; status=2; `snap_rx_pkt_cnt` = tx−1.
- **Abort and start-while-busy:** abort on RUN cycle 5 of 10. Required response:
  - `gen_en` low next cycle; `done` next cycle; status=3; `snap_cycles`=5.
  - A `start` asserted during that RUN has no effect.
- **Async reset mid-SETTLE:** required response: all outputs 0 without waiting for a clock edge; a new start afterwards runs normally.

Source files
------------

// File: rtl/easyobv_test_seq.sv
// easyobv_test_seq
// Runs one timed loopback test per start request: CLEAR -> SETTLE -> RUN ->
// DRAIN -> DONE. Drives the traffic-generator enable and the monitor clear,
// and latches a snapshot of the monitor counters plus a status code on entry
// to DONE.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start, abort              test control (start sampled only in IDLE)
//   settle_cycles, run_cycles per-test cycle counts, latched at start
//   mon_tx/rx_pkt_cnt         live monitor packet counts
//   mon_mismatch              live monitor mismatch flag
//   mon_clear, gen_en         monitor clear / generator enable
//   busy, done                not-IDLE flag / one-cycle completion pulse
//   status                    0 OK, 1 MISMATCH, 2 DRAIN_TIMEOUT, 3 ABORTED
//   snap_tx/rx_pkt_cnt        counts captured on entry to DONE
//   snap_cycles               RUN cycles actually executed
module easyobv_test_seq #(
  parameter int CNT_WIDTH     = 32,
  parameter int CLEAR_CYCLES  = 4,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] settle_cycles,
  input  logic [CNT_WIDTH-1:0] run_cycles,
  input  logic [63:0]          mon_tx_pkt_cnt,
  input  logic [63:0]          mon_rx_pkt_cnt,
  input  logic                 mon_mismatch,
  output logic                 mon_clear,
  output logic                 gen_en,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic [63:0]          snap_tx_pkt_cnt,
  output logic [63:0]          snap_rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0] snap_cycles
);

  // Phase counter must hold settle counts, CLEAR_CYCLES and DRAIN_TIMEOUT.
  localparam int DW  = $clog2(DRAIN_TIMEOUT + 1);
  localparam int KW  = $clog2(CLEAR_CYCLES + 1);
  localparam int CW0 = (CNT_WIDTH > DW) ? CNT_WIDTH : DW;
  localparam int CW  = (CW0 > KW) ? CW0 : KW;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_MIS = 2'd1;
  localparam logic [1:0] ST_TO  = 2'd2;
  localparam logic [1:0] ST_AB  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] settle_q, settle_d;
  logic [CNT_WIDTH-1:0] run_q, run_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic                 sticky_q, sticky_d;
  logic [1:0]           status_q, status_d;
  logic [63:0]          snap_tx_q, snap_tx_d;
  logic [63:0]          snap_rx_q, snap_rx_d;
  logic                 mon_clear_q, gen_en_q, busy_q, done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    run_d     = run_q;
    cyc_d     = cyc_q;
    sticky_d  = sticky_q;
    status_d  = status_q;
    snap_tx_d = snap_tx_q;
    snap_rx_d = snap_rx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          settle_d = settle_cycles;
          run_d    = (run_cycles == '0) ? CNT_WIDTH'(1) : run_cycles;
          sticky_d = 1'b0;
          cyc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CW'(CLEAR_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (settle_q == '0) ? S_RUN : S_SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(settle_q) - CW'(1)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        sticky_d = sticky_q | mon_mismatch;
        cyc_d    = (cyc_q == '1) ? cyc_q : cyc_q + CNT_WIDTH'(1);
        // cyc_q counts completed RUN cycles; this one is the last.
        if (cyc_q == run_q - CNT_WIDTH'(1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        sticky_d = sticky_q | mon_mismatch;
        if (mon_rx_pkt_cnt == mon_tx_pkt_cnt) begin
          cnt_d    = '0;
          state_d  = S_DONE;
          status_d = sticky_d ? ST_MIS : ST_OK;
        end else if (cnt_q == CW'(DRAIN_TIMEOUT - 1)) begin
          cnt_d    = '0;
          state_d  = S_DONE;
          status_d = ST_TO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every active state; IDLE (start wins) and DONE ignore it.
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      cnt_d    = '0;
      state_d  = S_DONE;
      status_d = ST_AB;
    end

    if (state_d == S_DONE && state_q != S_DONE) begin
      snap_tx_d = mon_tx_pkt_cnt;
      snap_rx_d = mon_rx_pkt_cnt;
    end
  end

  // Outputs are decoded from the next state so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      settle_q    <= '0;
      run_q       <= '0;
      cyc_q       <= '0;
      sticky_q    <= 1'b0;
      status_q    <= ST_OK;
      snap_tx_q   <= '0;
      snap_rx_q   <= '0;
      mon_clear_q <= 1'b0;
      gen_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      run_q       <= run_d;
      cyc_q       <= cyc_d;
      sticky_q    <= sticky_d;
      status_q    <= status_d;
      snap_tx_q   <= snap_tx_d;
      snap_rx_q   <= snap_rx_d;
      mon_clear_q <= (state_d == S_CLEAR);
      gen_en_q    <= (state_d == S_RUN);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign mon_clear       = mon_clear_q;
  assign gen_en          = gen_en_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign status          = status_q;
  assign snap_tx_pkt_cnt = snap_tx_q;
  assign snap_rx_pkt_cnt = snap_rx_q;
  assign snap_cycles     = cyc_q;

endmodule

// File: tb/tb_easyobv_test_seq.sv
module tb_easyobv_test_seq;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] settle_cycles = '0;
  logic [CW-1:0] run_cycles = '0;
  logic [63:0]   mon_tx_pkt_cnt = '0;
  logic [63:0]   mon_rx_pkt_cnt = '0;
  logic          mon_mismatch = 1'b0;
  logic          mon_clear, gen_en, busy, done;
  logic [1:0]    status;
  logic [63:0]   snap_tx_pkt_cnt, snap_rx_pkt_cnt;
  logic [CW-1:0] snap_cycles;

  easyobv_test_seq #(.CNT_WIDTH(CW), .CLEAR_CYCLES(4), .DRAIN_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .settle_cycles(settle_cycles), .run_cycles(run_cycles),
    .mon_tx_pkt_cnt(mon_tx_pkt_cnt), .mon_rx_pkt_cnt(mon_rx_pkt_cnt),
    .mon_mismatch(mon_mismatch), .mon_clear(mon_clear), .gen_en(gen_en),
    .busy(busy), .done(done), .status(status),
    .snap_tx_pkt_cnt(snap_tx_pkt_cnt), .snap_rx_pkt_cnt(snap_rx_pkt_cnt),
    .snap_cycles(snap_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [63:0] tx;
    logic [63:0] rx;
    int          cyc;
    int          gen;
    int          clr;
    int          lat;   // periods from first busy cycle to done
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: counts enables per test and scores each done pulse.
  initial begin
    int cyc = 0, busy_cyc = 0, gen_cnt = 0, clr_cnt = 0;
    logic busy_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_prev = 1'b0;
        gen_cnt = 0;
        clr_cnt = 0;
      end else begin
        cyc++;
        if (busy && !busy_prev) begin
          busy_cyc = cyc;
          gen_cnt = 0;
          clr_cnt = 0;
        end
        if (gen_en) gen_cnt++;
        if (mon_clear) clr_cnt++;
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("status", 64'(status), 64'(e.st));
            chk("snap_tx", snap_tx_pkt_cnt, e.tx);
            chk("snap_rx", snap_rx_pkt_cnt, e.rx);
            chk("snap_cycles", 64'(snap_cycles), 64'(e.cyc));
            chk("gen_en_cycles", 64'(gen_cnt), 64'(e.gen));
            chk("mon_clear_cycles", 64'(clr_cnt), 64'(e.clr));
            chk("done_latency", 64'(cyc - busy_cyc), 64'(e.lat));
          end
        end
        busy_prev = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int s, input int r);
    settle_cycles = CW'(s);
    run_cycles    = CW'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done) seen = 1;
      else tick();
    end
    if (!seen) chk({name, "_done_timeout"}, 0, 1);
    tick();
  endtask

  task automatic wait_gen(input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (gen_en) seen = 1;
      else tick();
    end
    if (!seen) chk({name, "_gen_timeout"}, 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mon_clear"}, 64'(mon_clear), 0);
    chk({tag, "_gen_en"}, 64'(gen_en), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_status"}, 64'(status), 0);
    chk({tag, "_snap_tx"}, snap_tx_pkt_cnt, 0);
    chk({tag, "_snap_rx"}, snap_rx_pkt_cnt, 0);
    chk({tag, "_snap_cycles"}, 64'(snap_cycles), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Nominal: clear 4, settle 3, run 10, counts equal -> done 19 after start edge.
    mon_tx_pkt_cnt = 100; mon_rx_pkt_cnt = 100;
    exp_q.push_back('{st: 2'd0, tx: 100, rx: 100, cyc: 10, gen: 10, clr: 4, lat: 18});
    do_start(3, 10);
    wait_done("nominal");
    chk("nominal_idle_busy", 64'(busy), 0);

    // Zero counts: no SETTLE, one RUN cycle.
    mon_tx_pkt_cnt = 7; mon_rx_pkt_cnt = 7;
    exp_q.push_back('{st: 2'd0, tx: 7, rx: 7, cyc: 1, gen: 1, clr: 4, lat: 6});
    do_start(0, 0);
    wait_done("zero");

    // Mismatch pulse on RUN cycle 3; counts become equal before drain.
    mon_tx_pkt_cnt = 20; mon_rx_pkt_cnt = 19;
    exp_q.push_back('{st: 2'd1, tx: 20, rx: 20, cyc: 6, gen: 6, clr: 4, lat: 13});
    do_start(2, 6);
    wait_gen("mismatch");
    tick(); tick();
    mon_mismatch = 1'b1;
    tick();
    mon_mismatch = 1'b0;
    mon_rx_pkt_cnt = 20;
    wait_done("mismatch");

    // Drain timeout: rx held at tx-1, 8 drain cycles.
    mon_tx_pkt_cnt = 50; mon_rx_pkt_cnt = 49;
    exp_q.push_back('{st: 2'd2, tx: 50, rx: 49, cyc: 4, gen: 4, clr: 4, lat: 17});
    do_start(1, 4);
    wait_done("timeout");

    // Abort on RUN cycle 5 of 10, with a start pulse during RUN cycle 2.
    mon_tx_pkt_cnt = 30; mon_rx_pkt_cnt = 30;
    exp_q.push_back('{st: 2'd3, tx: 30, rx: 30, cyc: 5, gen: 5, clr: 4, lat: 11});
    do_start(2, 10);
    wait_gen("abort");
    tick();
    settle_cycles = '0; run_cycles = CW'(1); start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_gen_low", 64'(gen_en), 0);
    chk("abort_done", 64'(done), 1);
    tick(); tick(); tick();
    chk("abort_no_restart", 64'(busy), 0);

    // Async reset mid-SETTLE: outputs clear between clock edges, no done.
    do_start(10, 3);
    repeat (6) tick();
    chk("settle_busy", 64'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst = 1'b0;
    tick();

    // Normal run after reset.
    mon_tx_pkt_cnt = 5; mon_rx_pkt_cnt = 5;
    exp_q.push_back('{st: 2'd0, tx: 5, rx: 5, cyc: 10, gen: 10, clr: 4, lat: 18});
    do_start(3, 10);
    wait_done("post_reset");
    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
